// File: rtl/digit_scan.sv
// rtl/digit_scan.sv - two-digit display scan controller; optional blank interval via DIGIT_SCAN_BLANK_EN
module digit_scan #(
  parameter int nbits    = 7,
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [nbits-1:0] seg_in,
  output logic             dec,
  output logic [nbits-1:0] seg_out,
  output logic [1:0]       an,
  output logic             frame_done
);

  localparam logic [15:0] C_DWELL_LAST = 16'(PRESCALE - 1);
`ifdef DIGIT_SCAN_BLANK_EN
  localparam logic [15:0] C_BLANK_LAST = 16'(BLANK - 1);
`endif

  // Reject parameter values the 16-bit dwell counter or the blank interval cannot honour
  if (PRESCALE < 2 || PRESCALE > 65536) begin : g_chk_prescale
    $error("digit_scan: PRESCALE must lie in 2..65536");
  end
  if (BLANK < 1 || BLANK > 255) begin : g_chk_blank
    $error("digit_scan: BLANK must lie in 1..255");
  end

`ifdef DIGIT_SCAN_BLANK_EN
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SHOW_LSB = 3'd1,
    S_BLANK_A  = 3'd2,
    S_SHOW_MSB = 3'd3,
    S_BLANK_B  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SHOW_LSB = 3'd1,
    S_SHOW_MSB = 3'd3
  } state_t;
`endif

  state_t           r_state;
  logic [15:0]      r_cnt;
  logic             r_dec;
  logic [1:0]       r_an;
  logic [nbits-1:0] r_seg;
  logic             r_done;

  // Scan sequencer: state, dwell counter and every output move together on one edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dec   <= 1'b0;
      r_an    <= 2'b11;
      r_seg   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Pattern is sampled in every scanning state; IDLE holds the last one
      if (r_state != S_IDLE) begin
        r_seg <= seg_in;
      end
      if (!en) begin
        // Disable wins over any dwell expiry, so an abandoned frame never pulses
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_an    <= 2'b11;
        r_dec   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_cnt <= '0;
            r_dec <= 1'b0;
`ifdef DIGIT_SCAN_BLANK_EN
            r_state <= S_BLANK_B;
            r_an    <= 2'b11;
`else
            r_state <= S_SHOW_LSB;
            r_an    <= 2'b10;
`endif
          end
          S_SHOW_LSB: begin
            if (r_cnt == C_DWELL_LAST) begin
              r_cnt <= '0;
              r_dec <= 1'b1;
`ifdef DIGIT_SCAN_BLANK_EN
              r_state <= S_BLANK_A;
              r_an    <= 2'b11;
`else
              r_state <= S_SHOW_MSB;
              r_an    <= 2'b01;
`endif
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          S_SHOW_MSB: begin
            if (r_cnt == C_DWELL_LAST) begin
              r_cnt  <= '0;
              r_dec  <= 1'b0;
              r_done <= 1'b1;
`ifdef DIGIT_SCAN_BLANK_EN
              r_state <= S_BLANK_B;
              r_an    <= 2'b11;
`else
              r_state <= S_SHOW_LSB;
              r_an    <= 2'b10;
`endif
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
`ifdef DIGIT_SCAN_BLANK_EN
          S_BLANK_A: begin
            if (r_cnt == C_BLANK_LAST) begin
              r_cnt   <= '0;
              r_state <= S_SHOW_MSB;
              r_an    <= 2'b01;
              r_dec   <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          S_BLANK_B: begin
            if (r_cnt == C_BLANK_LAST) begin
              r_cnt   <= '0;
              r_state <= S_SHOW_LSB;
              r_an    <= 2'b10;
              r_dec   <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
`endif
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_an    <= 2'b11;
            r_dec   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dec        = r_dec;
  assign an         = r_an;
  assign seg_out    = r_seg;
  assign frame_done = r_done;

endmodule

// File: tb/tb_digit_scan.sv
// tb/tb_digit_scan.sv - self-checking bench for digit_scan (follows DIGIT_SCAN_BLANK_EN)
module tb_digit_scan;

  localparam int P = 4;
  localparam int B = 2;
`ifdef DIGIT_SCAN_BLANK_EN
  localparam int BE = B;
`else
  localparam int BE = 0;
`endif
  localparam int PERIOD = 2 * (P + BE);

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [6:0] seg_in;
  logic [6:0] seg_out;
  logic       dec;
  logic [1:0] an;
  logic       frame_done;
  logic [6:0] lsb_pat = 7'h3F;
  logic [6:0] msb_pat = 7'h06;

  // Behavioural mux stage upstream of the scanner
  assign seg_in = dec ? msb_pat : lsb_pat;

  digit_scan #(.nbits(7), .PRESCALE(P), .BLANK(B)) dut (
    .clk(clk), .rst(rst), .en(en), .seg_in(seg_in),
    .dec(dec), .seg_out(seg_out), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: position in the scan is just the number of edges since enable
  bit         m_active;
  int         m_t;
  logic [6:0] m_seg;
  logic [1:0] m_an;
  logic       m_dec;
  logic       m_done;

  function automatic void model_outputs();
    int s;
    int u;
    m_an   = 2'b11;
    m_dec  = 1'b0;
    m_done = 1'b0;
    if (m_active) begin
      s = m_t - BE;
      if (s >= 0) begin
        u = s % PERIOD;
        if (u < P)                begin m_an = 2'b10; m_dec = 1'b0; end
        else if (u < P + BE)      begin m_an = 2'b11; m_dec = 1'b1; end
        else if (u < 2 * P + BE)  begin m_an = 2'b01; m_dec = 1'b1; end
        else                      begin m_an = 2'b11; m_dec = 1'b0; end
        m_done = (s >= 2 * P + BE) && (((s - (2 * P + BE)) % PERIOD) == 0);
      end
    end
  endfunction

  function automatic void model_reset();
    m_active = 1'b0;
    m_t      = 0;
    m_seg    = 7'h00;
    model_outputs();
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".an"}, 32'(an), 32'(m_an));
    chk({tag, ".dec"}, 32'(dec), 32'(m_dec));
    chk({tag, ".seg_out"}, 32'(seg_out), 32'(m_seg));
    chk({tag, ".frame_done"}, 32'(frame_done), 32'(m_done));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".an"}, 32'(an), 32'h3);
    chk({tag, ".dec"}, 32'(dec), 32'h0);
    chk({tag, ".seg_out"}, 32'(seg_out), 32'h0);
    chk({tag, ".frame_done"}, 32'(frame_done), 32'h0);
  endtask

  // One clock edge: advance the model from the inputs that were stable before it
  task automatic tick();
    logic [6:0] mux_v;
    bit         was_active;
    was_active = m_active;
    mux_v      = m_dec ? msb_pat : lsb_pat;
    @(posedge clk);
    if (rst) begin
      if (was_active) m_seg = mux_v;
      if (!en) begin
        m_active = 1'b0;
        m_t      = 0;
      end else if (!m_active) begin
        m_active = 1'b1;
        m_t      = 0;
      end else begin
        m_t++;
      end
      model_outputs();
    end
    #1;
  endtask

  task automatic tick_chk(input string tag);
    tick();
    chk_model(tag);
  endtask

  typedef struct {
    logic       en;
    logic [1:0] an;
    logic       dec;
    logic [6:0] seg;
    logic       done;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int         rl;
    int         pulses;
    bit         found;
    bit         done_seen;
    logic [6:0] exp_seg;

`ifdef DIGIT_SCAN_BLANK_EN
    tbl[0]  = '{1'b1, 2'b11, 1'b0, 7'h00, 1'b0};
    tbl[1]  = '{1'b1, 2'b11, 1'b0, 7'h3F, 1'b0};
    tbl[2]  = '{1'b1, 2'b10, 1'b0, 7'h3F, 1'b0};
    tbl[3]  = '{1'b1, 2'b10, 1'b0, 7'h3F, 1'b0};
    tbl[4]  = '{1'b1, 2'b10, 1'b0, 7'h3F, 1'b0};
    tbl[5]  = '{1'b1, 2'b10, 1'b0, 7'h3F, 1'b0};
    tbl[6]  = '{1'b1, 2'b11, 1'b1, 7'h3F, 1'b0};
    tbl[7]  = '{1'b1, 2'b11, 1'b1, 7'h06, 1'b0};
    tbl[8]  = '{1'b1, 2'b01, 1'b1, 7'h06, 1'b0};
    tbl[9]  = '{1'b1, 2'b01, 1'b1, 7'h06, 1'b0};
    tbl[10] = '{1'b1, 2'b01, 1'b1, 7'h06, 1'b0};
    tbl[11] = '{1'b1, 2'b01, 1'b1, 7'h06, 1'b0};
    tbl[12] = '{1'b1, 2'b11, 1'b0, 7'h06, 1'b1};
    tbl[13] = '{1'b1, 2'b11, 1'b0, 7'h3F, 1'b0};
`else
    tbl[0]  = '{1'b1, 2'b10, 1'b0, 7'h00, 1'b0};
    tbl[1]  = '{1'b1, 2'b10, 1'b0, 7'h3F, 1'b0};
    tbl[2]  = '{1'b1, 2'b10, 1'b0, 7'h3F, 1'b0};
    tbl[3]  = '{1'b1, 2'b10, 1'b0, 7'h3F, 1'b0};
    tbl[4]  = '{1'b1, 2'b01, 1'b1, 7'h3F, 1'b0};
    tbl[5]  = '{1'b1, 2'b01, 1'b1, 7'h06, 1'b0};
    tbl[6]  = '{1'b1, 2'b01, 1'b1, 7'h06, 1'b0};
    tbl[7]  = '{1'b1, 2'b01, 1'b1, 7'h06, 1'b0};
    tbl[8]  = '{1'b1, 2'b10, 1'b0, 7'h06, 1'b1};
    tbl[9]  = '{1'b1, 2'b10, 1'b0, 7'h3F, 1'b0};
    tbl[10] = '{1'b1, 2'b10, 1'b0, 7'h3F, 1'b0};
    tbl[11] = '{1'b1, 2'b10, 1'b0, 7'h3F, 1'b0};
    tbl[12] = '{1'b1, 2'b01, 1'b1, 7'h3F, 1'b0};
    tbl[13] = '{1'b1, 2'b01, 1'b1, 7'h06, 1'b0};
`endif

    // Reset held with enable high
    model_reset();
    rst = 1'b0;
    en  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset_hold");

    // Release and follow the first frame edge by edge
    rst = 1'b1;
    for (int i = 0; i < 14; i++) begin
      en = tbl[i].en;
      tick();
      chk($sformatf("tbl%0d.an", i), 32'(an), 32'(tbl[i].an));
      chk($sformatf("tbl%0d.dec", i), 32'(dec), 32'(tbl[i].dec));
      chk($sformatf("tbl%0d.seg_out", i), 32'(seg_out), 32'(tbl[i].seg));
      chk($sformatf("tbl%0d.frame_done", i), 32'(frame_done), 32'(tbl[i].done));
      chk_model($sformatf("tbl%0d.model", i));
    end

    // Steady scan: exactly one pulse per frame period
    pulses = 0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      tick_chk("steady");
      if (frame_done) pulses++;
    end
    chk("steady.pulses", 32'(pulses), 32'd3);

    // Disable in the second SHOW_MSB cycle
    rl = 0;
    found = 1'b0;
    for (int i = 0; i < 2 * PERIOD && !found; i++) begin
      tick_chk("pre_dis");
      if (an == 2'b01) rl++; else rl = 0;
      if (rl == 2) found = 1'b1;
    end
    chk("dis.found_msb2", 32'(found), 32'd1);
    en = 1'b0;
    tick_chk("dis");
    chk("dis.an", 32'(an), 32'h3);
    chk("dis.dec", 32'(dec), 32'h0);
    chk("dis.frame_done", 32'(frame_done), 32'h0);
    tick_chk("dis_idle");
    en = 1'b1;
    tick_chk("reen");
`ifdef DIGIT_SCAN_BLANK_EN
    chk("reen.an_blank_b", 32'(an), 32'h3);
    chk("reen.dec_blank_b", 32'(dec), 32'h0);
`else
    chk("reen.an_lsb", 32'(an), 32'h2);
`endif

    // Disable on the very edge SHOW_MSB would exit
    rl = 0;
    found = 1'b0;
    for (int i = 0; i < 3 * PERIOD && !found; i++) begin
      tick_chk("pre_sim");
      if (an == 2'b01) rl++; else rl = 0;
      if (rl == P) found = 1'b1;
    end
    chk("sim.found_msb_last", 32'(found), 32'd1);
    en = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick_chk("sim");
      if (frame_done) done_seen = 1'b1;
      chk("sim.an", 32'(an), 32'h3);
    end
    chk("sim.no_pulse", 32'(done_seen), 32'd0);

    // Change the msb pattern while the lsb digit is lit
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 3 * PERIOD && !found; i++) begin
      tick_chk("pre_data");
      if (an == 2'b10) found = 1'b1;
    end
    chk("data.found_lsb", 32'(found), 32'd1);
    msb_pat = 7'h5B;
    found = 1'b0;
    for (int i = 0; i < 2 * PERIOD && !found; i++) begin
      tick_chk("data_wait");
      if (an == 2'b01) found = 1'b1;
    end
    chk("data.found_msb", 32'(found), 32'd1);
    for (int i = 0; i < P; i++) begin
`ifdef DIGIT_SCAN_BLANK_EN
      exp_seg = 7'h5B;
`else
      exp_seg = (i == 0) ? 7'h3F : 7'h5B;
`endif
      chk($sformatf("data.msb%0d.seg_out", i), 32'(seg_out), 32'(exp_seg));
      chk($sformatf("data.msb%0d.an", i), 32'(an), 32'h1);
      if (i != P - 1) tick_chk("data_msb");
    end

    // Asynchronous reset mid-frame
    repeat (3) tick_chk("pre_arst");
    #2;
    rst = 1'b0;
    #1;
    chk_reset_vals("arst");
    model_reset();
    tick();
    chk_reset_vals("arst_hold");
    rst = 1'b1;

    // Randomized run against the model
    for (int i = 0; i < 800; i++) begin
      en = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 9) == 0) lsb_pat = 7'($urandom);
      if ($urandom_range(0, 9) == 0) msb_pat = 7'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b0;
        #2;
        chk_reset_vals("rnd_arst");
        model_reset();
        rst = 1'b1;
      end
      tick_chk("rnd");
      chk("rnd.an_not_both", 32'(an == 2'b00), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_scan.md
# digit_scan

Two-digit display scan controller that sits directly downstream of the pipeline's 7-bit `mux` stage. It drives that stage's `dec` select, registers the selected 7-bit pattern, and time-multiplexes it onto two active-low digit enables with a programmable dwell and an anti-ghosting blank interval. It emits a one-cycle pulse at the end of each full two-digit frame.

## Interface
- `nbits`, 7, segment pattern width; matches the `mux` stage width.
- `PRESCALE`, 50000, dwell cycles per digit; legal range 2..65536.
- `BLANK`, 4, blank cycles between digits; legal range 1..255; used only with `DIGIT_SCAN_BLANK_EN`.

- `clk`  in  1  single system clock; rising edge.
- `rst`  in  1  asynchronous, active-low reset; reset applies while `rst`=0.
- `en`  in  1  scan enable, level-sensitive.
- `seg_in`  in  nbits  pattern from the `mux` `out` port, selected by `dec`.
- `dec`  out  1  `mux` select: 0 selects the lsb digit, 1 selects the msb digit.
- `seg_out`  out  nbits  registered segment pattern.
- `an`  out  2  active-low digit enables: `an[0]` is the lsb digit, `an[1]` is the msb digit.
- `frame_done`  out  1  one-cycle pulse when a frame completes.

## Operation
- States: IDLE, SHOW_LSB, BLANK_A, SHOW_MSB, BLANK_B.
- Dwell counter is 16 bits and is cleared on every state change.
- All outputs are registered. None are decoded combinationally from the state.
- **Reset values:** state = IDLE, `dec`=0, `an`=2'b11, `seg_out`=0, `frame_done`=0, counter = 0.
- **IDLE:**
  - Outputs: `an`=11, `dec`=0.
  - `en`=1 → BLANK_B. This gives a first capture before any digit lights.
- **SHOW_LSB:**
  - Outputs: `an`=10, `dec`=0.
  - Counter reaching PRESCALE-1 → BLANK_A.
- **BLANK_A:**
  - Outputs: `an`=11, `dec`=1.
  - Counter reaching BLANK-1 → SHOW_MSB.
- **SHOW_MSB:**
  - Outputs: `an`=01, `dec`=1.
  - Counter reaching PRESCALE-1 → BLANK_B.
  - `frame_done`=1 for exactly the first cycle after this exit.
- **BLANK_B:**
  - Outputs: `an`=11, `dec`=0.
  - Counter reaching BLANK-1 → SHOW_LSB.
- **Capture:**
  - `seg_out` <= `seg_in` on every edge where the current state is BLANK_x or SHOW_x.
  - `seg_out` holds in IDLE.
  - `dec` is already stable for the upcoming digit during its blank interval, so `seg_out` is correct before the digit's `an` goes low.
- **Disable:** `en`=0 in any state → IDLE on the next edge. The in-progress frame is abandoned, no `frame_done` is emitted, and `seg_out` holds its last value.
- **Enable and exit on the same edge:** if `en` falls on the same edge where SHOW_MSB would exit, IDLE wins and no `frame_done` is emitted.
- **Re-enable** always restarts from BLANK_B. The frame position is not resumed.
- **Reset mid-frame:** asynchronous return to the reset values, with no pulse.

## Timing
- `dec` and `an` change on the same clock edge as the state change that causes them.
- `seg_out` latency is one cycle after `seg_in`.
- Frame period with the blank feature is 2·(PRESCALE+BLANK) cycles.
- A digit enable is low for exactly PRESCALE consecutive cycles, and the two enables are never low simultaneously.
- First lit digit is the lsb digit: its `an` falls BLANK+1 edges after the `en` rising edge is sampled.

## Configuration
- **Macro:** `DIGIT_SCAN_BLANK_EN`.
- **Defined:** behaviour exactly as above.
- **Undefined:**
  - BLANK_A and BLANK_B are removed; SHOW_LSB → SHOW_MSB → SHOW_LSB directly.
  - IDLE with `en`=1 goes straight to SHOW_LSB.
  - Capture occurs in SHOW states only, so the first cycle of each digit shows the previous digit's pattern. This one-cycle ghost is accepted.
  - Frame period is 2·PRESCALE cycles; the `BLANK` parameter is ignored.

## Test plan
All scenarios use PRESCALE=4, BLANK=2 and a behavioural `mux` model (lsb=7'h3F, msb=7'h06) unless stated.
- **Reset:** hold `rst`=0 with `en`=1 → `an`=11, `dec`=0, `seg_out`=0, `frame_done`=0. Release → `an`[0] falls on edge 3 after release with `seg_out`=7'h3F.
- **Steady scan:** run 3 frames → 12-cycle period; `an` sequence per frame is 10×4, 11×2, 01×4, 11×2. `seg_out`=7'h06 whenever `an`=01. One `frame_done` pulse per frame, on the first BLANK_B cycle.
- **Disable mid-frame:** drop `en` in the 2nd SHOW_MSB cycle → next edge gives `an`=11, `dec`=0, no pulse. Re-raise `en` → restart through BLANK_B.
- **Simultaneous end:** drop `en` on the SHOW_MSB exit edge → IDLE with `frame_done` never asserted.
- **Data change:** change msb to 7'h5B during SHOW_LSB → the following SHOW_MSB shows 7'h5B for all 4 cycles.
- **Macro undefined:** period is 8 cycles with no `an`=11 cycles while enabled. The first cycle of SHOW_MSB has `seg_out`=7'h3F, then 7'h06.
